pipe_column_gen: RTL and testbench
==================================

# pipe_column_gen

Generates the obstacle pattern for the scrolling playfield one column at a time. On every frame tick it produces a ROWS-bit column containing either a pipe segment with a pseudo-random gap or empty space. Columns are delivered over a valid/ready handshake to the obstacle shift-register bank. Each bank row takes its bit of the column as its serial input, and the downstream shift strobe is the handshake acceptance.

## Interface
- ROWS, 30: rows per column, one per obstacle shift register.
- PIPE_PERIOD, 10: columns from one pipe start to the next.
- PIPE_WIDTH, 2: columns of each pipe that are solid. Must be less than or equal to PIPE_PERIOD.
- GAP_ROWS, 8: height of the open gap in rows.
- MIN_GAP_TOP, 2: minimum number of solid rows above and below the gap.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset. Must be nonzero.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-low.
- resetn  in  1  synchronous active-low reset.
- enable  in  1  when 0, ticks are ignored.
- tick  in  1  one-cycle frame strobe.
- col_ready  in  1  consumer accepts the column.
- col_valid  out  1  column available.
- col_data  out  ROWS  column bits. Bit r is row r; 1 means obstacle.
- gap_top  out  5  first open row of the current pipe.
- pipe_count  out  8  pipes started. Saturates at 255.
- overrun  out  1  sticky flag: a tick was dropped.

## Operation
- State machine:
  - IDLE: a tick with enable=1 moves to GEN.
  - GEN: lasts exactly one cycle, then moves to VALID.
  - VALID: on col_ready=1, moves to GEN if tick and enable are both 1 in that cycle; otherwise moves to IDLE.
- Column phase counter `phase` runs 0..PIPE_PERIOD-1. It advances in GEN after the column is built and wraps to 0.
- Pipe start, in GEN when phase==0:
  - Advance the LFSR one step first.
  - Compute raw = lfsr[4:0] using the new LFSR value.
  - Compute RANGE = ROWS-GAP_ROWS-2*MIN_GAP_TOP+1, which is 19 with the defaults.
  - If raw ≥ RANGE, subtract RANGE once.
  - gap_top = MIN_GAP_TOP + raw.
  - Increment pipe_count, saturating at 255.
- LFSR is Galois, right shift: next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0). It advances only at pipe starts.
- Column contents:
  - phase < PIPE_WIDTH: col_data[r] = 1 except for gap_top ≤ r ≤ gap_top+GAP_ROWS-1, which are 0.
  - Otherwise: col_data is all zeros.
- Overrun: a tick with enable=1 arriving in GEN, or in VALID with col_ready=0, is dropped. It sets overrun, which stays set until reset. phase and the LFSR do not change.
- enable=0: ticks are ignored and do not set overrun. A column already in flight still completes its handshake.

## Timing
- Reset values: col_valid=0, col_data=0, gap_top=0, pipe_count=0, overrun=0, phase=0, lfsr=LFSR_SEED, state=IDLE.
- Reset applies at the next clock edge from any state, including mid-handshake. The column in flight is discarded.
- All outputs are registered.
- Latency: a tick sampled at edge N puts the FSM in GEN. At edge N+1 col_valid=1 and col_data, gap_top and pipe_count are updated.
- While col_valid=1 without col_ready, col_data and gap_top hold stable.
- Transfer happens on the edge where col_valid and col_ready are both 1. col_valid drops at that edge unless a simultaneous tick sends the FSM to GEN.
- After a simultaneous tick, col_valid is low for one cycle (GEN), then rises with the new column.
- Maximum throughput is one column per 2 cycles. Frame ticks are far slower than this.

## Structure
- Shared package `flappy_pkg` holds:
  - ROWS, the playfield dimensions and cell size;
  - LFSR_TAPS=16'hB400 and LFSR_SEED;
  - the state encoding constants IDLE, GEN and VALID.
  - The obstacle bank and renderer use the same package.
- Sub-module `lfsr16` contains the Galois step, a seed load on reset and an advance enable.
- Gap masking and the RANGE subtraction stay in the top level.

## Test plan
- Reset: assert resetn=0 for 2 cycles → col_valid=0, col_data=0, gap_top=0, pipe_count=0, overrun=0.
- First pipe (col_ready=1, enable=1): tick →
  - 2 cycles later col_valid is high for 1 cycle;
  - lfsr=16'hE270, raw=16, gap_top=18;
  - col_data=30'h3C03FFFF, pipe_count=1.
  - A second tick gives 30'h3C03FFFF again. The third through tenth ticks each give 30'h0.
- Second pipe (eleventh tick): lfsr=16'h7138, raw=24, so 24-19=5 and gap_top=7.
  - col_data has bits 7..14 clear and all others set: 30'h3FFF807F.
  - pipe_count=2.
- Backpressure: hold col_ready=0 after a column is valid, then tick →
  - overrun=1, col_data unchanged, phase unchanged.
  - Raise col_ready → transfer completes, FSM returns to IDLE, overrun stays 1.
- Simultaneous events:
  - tick and col_ready in the same VALID cycle → one cycle with col_valid=0, then the next column; overrun=0.
  - enable=0 with 5 ticks → no col_valid pulses, pipe_count and phase unchanged.
- Reset mid-VALID: drive resetn=0 while col_valid=1 → all outputs return to their reset values at the next edge. The next tick reproduces gap_top=18.

Source files
------------

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared playfield dimensions, LFSR constants and FSM encodings
package flappy_pkg;
    localparam int ROWS      = 30;
    localparam int COLS      = 40;
    localparam int CELL_SIZE = 16;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GEN   = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit right-shifting Galois LFSR with seed load and advance enable
module lfsr16
#(
    parameter logic [15:0] SEED  = flappy_pkg::LFSR_SEED,
    parameter logic [15:0] TAPS  = flappy_pkg::LFSR_TAPS,
    parameter int          OUT_W = 5
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             advance,
    output logic [OUT_W-1:0] next_bits
);
    logic [15:0] state;
    logic [15:0] stepped;

    // next_bits exposes the post-step value so a consumer sees it in the same cycle it advances
    always_comb begin
        stepped   = {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0);
        next_bits = stepped[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= SEED;
        end else if (advance) begin
            state <= stepped;
        end
    end
endmodule

// File: rtl/pipe_column_gen.sv
// rtl/pipe_column_gen.sv - per-tick obstacle column generator with valid/ready output
module pipe_column_gen
#(
    parameter int          ROWS        = flappy_pkg::ROWS,
    parameter int          PIPE_PERIOD = 10,
    parameter int          PIPE_WIDTH  = 2,
    parameter int          GAP_ROWS    = 8,
    parameter int          MIN_GAP_TOP = 2,
    parameter logic [15:0] LFSR_SEED   = flappy_pkg::LFSR_SEED
)
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic            tick,
    input  logic            col_ready,
    output logic            col_valid,
    output logic [ROWS-1:0] col_data,
    output logic [4:0]      gap_top,
    output logic [7:0]      pipe_count,
    output logic            overrun
);
    import flappy_pkg::*;

    localparam int         RANGE   = ROWS - GAP_ROWS - 2*MIN_GAP_TOP + 1;
    localparam int         PHASE_W = (PIPE_PERIOD > 1) ? $clog2(PIPE_PERIOD) : 1;
    localparam logic [4:0] RANGE_V = 5'(RANGE);
    localparam logic [4:0] MIN_V   = 5'(MIN_GAP_TOP);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PIPE_PERIOD - 1);

    logic [1:0]         state;
    logic [PHASE_W-1:0] phase;
    logic [4:0]         raw;
    logic [4:0]         raw_adj;
    logic [4:0]         gap_new;
    logic [4:0]         gap_cur;
    logic [ROWS-1:0]    col_next;
    logic               pipe_start;
    logic               trig;

    assign trig       = tick && enable;
    assign pipe_start = (state == GEN) && (phase == '0);

    lfsr16 #(.SEED(LFSR_SEED), .TAPS(LFSR_TAPS), .OUT_W(5)) u_lfsr (
        .clk       (clk),
        .resetn    (resetn),
        .advance   (pipe_start),
        .next_bits (raw)
    );

    // a single conditional subtract suffices because the 5-bit raw never reaches 2*RANGE
    always_comb begin
        raw_adj = (raw >= RANGE_V) ? (raw - RANGE_V) : raw;
        gap_new = MIN_V + raw_adj;
        gap_cur = pipe_start ? gap_new : gap_top;
        col_next = '0;
        if (int'(phase) < PIPE_WIDTH) begin
            for (int r = 0; r < ROWS; r++) begin
                col_next[r] = !((r >= int'(gap_cur)) && (r < int'(gap_cur) + GAP_ROWS));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            phase      <= '0;
            col_valid  <= 1'b0;
            col_data   <= '0;
            gap_top    <= '0;
            pipe_count <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) state <= GEN;
                end
                GEN: begin
                    state     <= VALID;
                    col_valid <= 1'b1;
                    col_data  <= col_next;
                    phase     <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
                    if (pipe_start) begin
                        gap_top <= gap_new;
                        if (pipe_count != 8'hFF) pipe_count <= pipe_count + 8'd1;
                    end
                    if (trig) overrun <= 1'b1;
                end
                VALID: begin
                    if (col_ready) begin
                        col_valid <= 1'b0;
                        state     <= trig ? GEN : IDLE;
                    end else if (trig) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_column_gen.sv
// tb/tb_pipe_column_gen.sv - randomized self-checking bench with a column-sequence reference model
module tb_pipe_column_gen;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b1;
    logic        tick = 1'b0;
    logic        col_ready = 1'b1;
    logic        col_valid;
    logic [29:0] col_data;
    logic [4:0]  gap_top;
    logic [7:0]  pipe_count;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_lfsr;
    int          m_phase;
    int          m_gap;
    int          m_count;

    always #5 clk = ~clk;

    pipe_column_gen dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .tick       (tick),
        .col_ready  (col_ready),
        .col_valid  (col_valid),
        .col_data   (col_data),
        .gap_top    (gap_top),
        .pipe_count (pipe_count),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_phase = 0;
        m_gap   = 0;
        m_count = 0;
    endtask

    task automatic model_column(output logic [29:0] col);
        int raw;
        if (m_phase == 0) begin
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            raw = m_lfsr % 32;
            if (raw >= 19) raw = raw - 19;
            m_gap = 2 + raw;
            if (m_count < 255) m_count++;
        end
        col = '0;
        if (m_phase < 2)
            for (int r = 0; r < 30; r++) col[r] = (r < m_gap) || (r >= m_gap + 8);
        m_phase = (m_phase + 1) % 10;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick = 1'b0;
        enable = 1'b1;
        step();
        step();
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic send_tick(input bit en);
        tick = 1'b1;
        enable = en;
        step();
        tick = 1'b0;
        enable = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 8 && !col_valid; i++) step();
        if (!col_valid) check({tag, "_timeout"}, 32'(col_valid), 32'd1);
    endtask

    // Waits for a column, checks it against the model, stalls 'delay' cycles, then accepts
    task automatic expect_column(input string tag, input int delay);
        logic [29:0] exp;
        col_ready = (delay == 0);
        wait_valid(tag);
        model_column(exp);
        check({tag, "_data"}, 32'(col_data), 32'(exp));
        check({tag, "_gap"}, 32'(gap_top), 32'(m_gap));
        check({tag, "_count"}, 32'(pipe_count), 32'(m_count));
        for (int d = 0; d < delay; d++) begin
            step();
            check({tag, "_hold"}, 32'(col_data), 32'(exp));
        end
        col_ready = 1'b1;
        step();
        check({tag, "_drop"}, 32'(col_valid), 32'd0);
    endtask

    initial begin
        logic [29:0] held;
        int en;

        do_reset();
        check("rst_valid", 32'(col_valid), 32'd0);
        check("rst_data", 32'(col_data), 32'd0);
        check("rst_gap", 32'(gap_top), 32'd0);
        check("rst_count", 32'(pipe_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        col_ready = 1'b1;
        send_tick(1);
        check("p1_gen_low", 32'(col_valid), 32'd0);
        step();
        check("p1_valid", 32'(col_valid), 32'd1);
        check("p1_data_const", 32'(col_data), 32'h3C03FFFF);
        check("p1_gap_const", 32'(gap_top), 32'd18);
        check("p1_count_const", 32'(pipe_count), 32'd1);
        model_column(held);
        check("p1_model", 32'(col_data), 32'(held));
        step();
        check("p1_pulse_end", 32'(col_valid), 32'd0);

        for (int t = 2; t <= 10; t++) begin
            send_tick(1);
            expect_column("seq", 0);
        end

        send_tick(1);
        wait_valid("p2");
        check("p2_data_const", 32'(col_data), 32'h3FFF807F);
        check("p2_gap_const", 32'(gap_top), 32'd7);
        check("p2_count_const", 32'(pipe_count), 32'd2);
        model_column(held);
        step();

        // Backpressure: the dropped tick must not advance phase or LFSR
        col_ready = 1'b0;
        send_tick(1);
        wait_valid("bp");
        model_column(held);
        check("bp_data", 32'(col_data), 32'(held));
        send_tick(1);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_hold", 32'(col_data), 32'(held));
        check("bp_still_valid", 32'(col_valid), 32'd1);
        col_ready = 1'b1;
        step();
        check("bp_drop", 32'(col_valid), 32'd0);
        step();
        check("bp_idle", 32'(col_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);
        send_tick(1);
        expect_column("bp_next", 0);

        do_reset();
        col_ready = 1'b1;
        send_tick(1);
        wait_valid("sim");
        model_column(held);
        check("sim_first", 32'(col_data), 32'(held));
        send_tick(1);
        check("sim_gap_cycle", 32'(col_valid), 32'd0);
        step();
        check("sim_second_valid", 32'(col_valid), 32'd1);
        model_column(held);
        check("sim_second_data", 32'(col_data), 32'(held));
        check("sim_overrun", 32'(overrun), 32'd0);
        step();

        for (int i = 0; i < 5; i++) begin
            send_tick(0);
            step();
            check("dis_no_valid", 32'(col_valid), 32'd0);
        end
        check("dis_count", 32'(pipe_count), 32'(m_count));
        check("dis_overrun", 32'(overrun), 32'd0);
        send_tick(1);
        expect_column("dis_resume", 0);

        col_ready = 1'b0;
        send_tick(1);
        wait_valid("rmv");
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_reset();
        check("rmv_valid", 32'(col_valid), 32'd0);
        check("rmv_data", 32'(col_data), 32'd0);
        check("rmv_gap", 32'(gap_top), 32'd0);
        check("rmv_count", 32'(pipe_count), 32'd0);
        check("rmv_overrun", 32'(overrun), 32'd0);
        send_tick(1);
        expect_column("rmv_again", 1);
        check("rmv_gap18", 32'(gap_top), 32'd18);

        for (int i = 0; i < 300; i++) begin
            en = ($urandom % 4) != 0;
            send_tick(en[0]);
            if (en != 0) begin
                expect_column("rand", int'($urandom_range(0, 3)));
            end else begin
                step();
                check("rand_disabled", 32'(col_valid), 32'd0);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        check("rand_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
